malch_ctrl: RTL and testbench



---
 rtl/malch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_malch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/malch_ctrl.sv
// malch_ctrl -- round sequencer and data-loop controller for the malch
// AES-128 encryption datapath.
//
// Accepts a plaintext/key pair on a start strobe, then walks the datapath
// through ADD0, ROUNDS-1 full rounds (SUB, SHI, MIX, ADDR) and a final round
// without MixColumns (SUB, SHI, ADDR). It closes the OUT->IN and EXKEY->KEY
// feedback loops and captures the ciphertext after the last AddRoundKey.
//
// Ports:
//   clk       in   1    single clock, all state on posedge
//   rst       in   1    synchronous active-high reset
//   start     in   1    request an encryption (sampled only in IDLE)
//   hold      in   1    stall; freezes sequencing in the round states
//   pt_in     in   128  plaintext, used in the cycle start is accepted
//   key_in    in   128  cipher key, used in the cycle start is accepted
//   dp_out    in   128  datapath OUT
//   dp_exkey  in   128  datapath EXKEY
//   cs        out  3    datapath state code (RES/ADD/SUB/SHI/MIX/FIN)
//   count     out  8    round number for expandKey
//   dp_in     out  128  datapath IN
//   dp_key    out  128  datapath KEY
//   busy      out  1    high from ADD0 through DONE
//   done      out  1    one-cycle pulse in DONE
//   ct_out    out  128  ciphertext, held until the next completion
module malch_ctrl #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         hold,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    input  logic [127:0] dp_out,
    input  logic [127:0] dp_exkey,
    output logic [2:0]   cs,
    output logic [7:0]   count,
    output logic [127:0] dp_in,
    output logic [127:0] dp_key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ct_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD0,
        ST_SUB,
        ST_SHI,
        ST_MIX,
        ST_ADDR,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        CS_RES = 3'b000,
        CS_ADD = 3'b010,
        CS_SUB = 3'b011,
        CS_SHI = 3'b100,
        CS_MIX = 3'b101,
        CS_FIN = 3'b111
    } cs_e;

    localparam logic [7:0] LAST = 8'(ROUNDS);

    state_e       state_q, state_d;
    logic [7:0]   count_q, count_d;
    logic [127:0] ct_q, ct_d;
    cs_e          cs_code;
    logic         in_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ct_d     = ct_q;
        cs_code  = CS_RES;
        in_round = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_code = CS_RES;
                count_d = '0;
                if (start) state_d = ST_ADD0;
            end
            ST_ADD0: begin
                cs_code  = CS_ADD;
                in_round = 1'b1;
                if (!hold) begin
                    state_d = ST_SUB;
                    count_d = 8'd1;
                end
            end
            ST_SUB: begin
                cs_code  = CS_SUB;
                in_round = 1'b1;
                if (!hold) state_d = ST_SHI;
            end
            ST_SHI: begin
                cs_code  = CS_SHI;
                in_round = 1'b1;
                // Final round skips MixColumns.
                if (!hold) state_d = (count_q < LAST) ? ST_MIX : ST_ADDR;
            end
            ST_MIX: begin
                cs_code  = CS_MIX;
                in_round = 1'b1;
                if (!hold) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cs_code  = CS_ADD;
                in_round = 1'b1;
                if (!hold) begin
                    if (count_q < LAST) begin
                        state_d = ST_SUB;
                        count_d = count_q + 8'd1;
                    end else begin
                        // dp_out already holds the last AddRoundKey result.
                        state_d = ST_DONE;
                        ct_d    = dp_out;
                    end
                end
            end
            ST_DONE: begin
                cs_code = CS_FIN;
                state_d = ST_IDLE;
                count_d = '0;
            end
            default: begin
                cs_code = CS_RES;
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        // A stall turns the step into a datapath no-op; the same step
        // re-executes once hold drops.
        if (hold && in_round) cs_code = CS_FIN;
    end

    assign cs     = cs_code;
    assign count  = count_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign ct_out = ct_q;
    assign dp_in  = (state_q == ST_IDLE) ? pt_in  : dp_out;
    assign dp_key = (state_q == ST_IDLE) ? key_in : dp_exkey;

endmodule

// File: tb/tb_malch_ctrl.sv
// Bench for malch_ctrl: a behavioural malch datapath closes the loop, a
// step-count model predicts per-cycle controller outputs, and a negedge
// monitor checks them against a scoreboard queue.
module tb_malch_ctrl;

    localparam int unsigned R = 10;
    localparam int unsigned NSTEPS = 4 * R;  // round-state steps per block

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic [127:0] pt_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] dp_out;
    logic [127:0] dp_exkey;
    logic [2:0]   cs;
    logic [7:0]   count;
    logic [127:0] dp_in;
    logic [127:0] dp_key;
    logic         busy;
    logic         done;
    logic [127:0] ct_out;

    malch_ctrl #(.ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .pt_in(pt_in), .key_in(key_in), .dp_out(dp_out), .dp_exkey(dp_exkey),
        .cs(cs), .count(count), .dp_in(dp_in), .dp_key(dp_key),
        .busy(busy), .done(done), .ct_out(ct_out)
    );

    always #5 clk = ~clk;

    // ---------------- AES primitives ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    task automatic fill_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rl1(inv) ^ rl1(rl1(inv)) ^ rl1(rl1(rl1(inv)))
                ^ rl1(rl1(rl1(rl1(inv)))) ^ 8'h63;
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xt(rc);
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        for (int rr = 1; rr <= int'(R); rr++) begin
            s = shift_rows(sub_bytes(s));
            if (rr < int'(R)) s = mix_cols(s);
            k = next_key(k, rr);
            s = s ^ k;
        end
        return s;
    endfunction

    // ---------------- behavioural malch datapath ----------------
    logic [127:0] emu_out, emu_key, emu_rk;
    assign dp_out   = emu_out;
    assign dp_exkey = emu_key;

    always @(negedge clk) begin
        case (cs)
            3'b000: begin emu_out <= dp_in; emu_key <= dp_key; end
            3'b010: begin
                emu_rk = (count == 8'd0) ? dp_key : next_key(dp_key, int'(count));
                emu_out <= dp_in ^ emu_rk;
                emu_key <= emu_rk;
            end
            3'b011: begin emu_out <= sub_bytes(dp_in);  emu_key <= dp_key; end
            3'b100: begin emu_out <= shift_rows(dp_in); emu_key <= dp_key; end
            3'b101: begin emu_out <= mix_cols(dp_in);   emu_key <= dp_key; end
            default: ;
        endcase
    end

    // ---------------- model + scoreboard ----------------
    typedef struct {
        logic [2:0]   cs;
        logic [7:0]   cnt;
        logic         busy;
        logic         done;
        logic [127:0] ct;
        logic         idle;
        logic [127:0] pt;
        logic [127:0] key;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_e;
    mmode_e       m_mode = M_IDLE;
    int           m_idx = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_pend = '0;
    bit           m_valid = 0;

    // Step idx 0 is ADD0; then R-1 rounds of four steps; then three final steps.
    function automatic logic [7:0] cnt_of(input int idx);
        if (idx == 0) return 8'd0;
        if (idx <= 4 * (int'(R) - 1)) return 8'((idx - 1) / 4 + 1);
        return 8'(R);
    endfunction

    function automatic logic [2:0] cs_of(input int idx);
        int m;
        if (idx == 0) return 3'b010;
        if (idx <= 4 * (int'(R) - 1)) begin
            m = (idx - 1) % 4;
            case (m)
                0: return 3'b011;
                1: return 3'b100;
                2: return 3'b101;
                default: return 3'b010;
            endcase
        end
        m = idx - 4 * (int'(R) - 1) - 1;
        case (m)
            0: return 3'b011;
            1: return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    task automatic tick(input logic r, input logic s, input logic h,
                        input logic [127:0] p, input logic [127:0] k,
                        input logic [127:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; start = s; hold = h; pt_in = p; key_in = k;
        if (m_valid) begin
            e.cyc  = cyc;
            e.ct   = m_ct;
            e.pt   = p;
            e.key  = k;
            e.idle = (m_mode == M_IDLE);
            case (m_mode)
                M_IDLE: begin e.cs = 3'b000; e.cnt = 8'd0; e.busy = 0; e.done = 0; end
                M_RUN: begin
                    e.cs = h ? 3'b111 : cs_of(m_idx);
                    e.cnt = cnt_of(m_idx); e.busy = 1; e.done = 0;
                end
                default: begin e.cs = 3'b111; e.cnt = 8'(R); e.busy = 1; e.done = 1; end
            endcase
            q.push_back(e);
        end
        if (r) begin
            m_mode = M_IDLE; m_ct = '0; m_valid = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin m_mode = M_RUN; m_idx = 0; m_pend = ec; end
                M_RUN: if (!h) begin
                    m_idx++;
                    if (m_idx == int'(NSTEPS)) begin m_mode = M_DONE; m_ct = m_pend; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input int c, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("cs",     e.cyc, 128'(cs),    128'(e.cs));
            chk("count",  e.cyc, 128'(count), 128'(e.cnt));
            chk("busy",   e.cyc, 128'(busy),  128'(e.busy));
            chk("done",   e.cyc, 128'(done),  128'(e.done));
            chk("ct_out", e.cyc, ct_out,      e.ct);
            if (e.idle) begin
                chk("dp_in",  e.cyc, dp_in,  e.pt);
                chk("dp_key", e.cyc, dp_key, e.key);
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, rnd128(), rnd128(), '0);
    endtask

    initial begin
        logic [127:0] p, k;
        logic         r, s, h;
        fill_sbox();

        // Reset, then FIPS-197 C.1.
        repeat (3) tick(1'b1, 1'b0, 1'b0, '0, '0, '0);
        tick(1'b0, 1'b1, 1'b0, P_C1, K_C1, CT_C1);
        idle_ticks(43);

        // FIPS-197 Appendix B.
        tick(1'b0, 1'b1, 1'b0, P_B, K_B, CT_B);
        idle_ticks(43);

        // Stalls: 3 cycles in round-1 MIX, 2 in a later SHI; hold in DONE/IDLE ignored.
        tick(1'b0, 1'b1, 1'b0, P_C1, K_C1, CT_C1);
        for (int c = 1; c <= 48; c++)
            tick(1'b0, 1'b0, (c inside {4, 5, 6, 10, 11, 46, 47}), rnd128(), rnd128(), '0);
        idle_ticks(2);

        // start at cycles 5 and 41 ignored; new start in cycle 42 accepted.
        tick(1'b0, 1'b1, 1'b0, P_B, K_B, CT_B);
        for (int c = 1; c <= 41; c++)
            tick(1'b0, (c == 5 || c == 41), 1'b0, P_C1, K_C1, 128'hdead);
        tick(1'b0, 1'b1, 1'b0, P_C1, K_C1, CT_C1);
        idle_ticks(43);

        // Reset mid-encryption at cycle 20, then a fresh run.
        p = rnd128(); k = rnd128();
        tick(1'b0, 1'b1, 1'b0, p, k, aes_ref(p, k));
        for (int c = 1; c <= 20; c++) tick((c == 20), 1'b0, 1'b0, rnd128(), rnd128(), '0);
        idle_ticks(2);
        tick(1'b0, 1'b1, 1'b0, P_B, K_B, CT_B);
        idle_ticks(43);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 3) == 0);
            p = rnd128();
            k = rnd128();
            tick(r, s, h, p, k, s ? aes_ref(p, k) : '0);
        end
        idle_ticks(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
